// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_pkg
// Description : Shared types and constants for the multi-player reaction
//               timer: FSM state encoding, LFSR feedback mask and the
//               winner-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    // Round FSM states; encoding is visible on the state output port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REACT = 2'd2,
        DONE  = 2'd3
    } rt_state_e;

    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Bits needed to index N players; at least one bit so N=1 still works.
    function automatic int win_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rt_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rt_lfsr
// Description : 16-bit Galois LFSR (taps 16,14,13,11) with load-on-reset
//               seed, step enable and a truncated output window.
// Revision    : 1.0 - initial release
// ============================================================================
module rt_lfsr
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_q
);

    logic [15:0] r_q;
    logic [15:0] w_next;

    // Shift right; when the bit leaving is 1, fold in the feedback mask.
    always_comb begin
        w_next = {1'b0, r_q[15:1]} ^ (r_q[0] ? c_lfsr_taps : 16'h0000);
    end

    // Register holds the seed while in reset and advances when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/reaction_timer_multi.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_multi
// Description : Multi-player reaction-timer core. Random foreplay delay,
//               light-on, per-player capture in ticks, false-start detection,
//               timeout, lowest-index winner arbitration and best-time hold.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_multi
    import reaction_pkg::*;
#(
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          TICK_HZ   = 1000,
    parameter int          N_PLAYERS = 4,
    parameter int          TIME_W    = 14,
    parameter int          MIN_DELAY = 1000,
    parameter int          DELAY_W   = 12,
    parameter int          TIMEOUT   = 9999,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    input  logic                          start,
    input  logic                          clear,
    input  logic [N_PLAYERS-1:0]          btn,
    output logic [1:0]                    state,
    output logic                          light_on,
    output logic [TIME_W-1:0]             delay_ticks,
    output logic [N_PLAYERS*TIME_W-1:0]   rt_time,
    output logic [N_PLAYERS-1:0]          rt_valid,
    output logic [N_PLAYERS-1:0]          false_start,
    output logic [2:0]                    winner,
    output logic                          winner_valid,
    output logic [TIME_W-1:0]             best_time,
    output logic                          best_valid
);

    localparam int                 c_div       = CLK_HZ / TICK_HZ;
    localparam int                 c_presc_w   = $clog2(c_div);
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(c_div - 1);
    localparam int                 c_win_w     = win_w(N_PLAYERS);
    localparam logic [TIME_W-1:0]  c_min_delay = TIME_W'(MIN_DELAY);
    localparam logic [TIME_W-1:0]  c_timeout   = TIME_W'(TIMEOUT);
    localparam logic [TIME_W-1:0]  c_one       = TIME_W'(1);

    // Registered state
    rt_state_e                      r_state;
    logic [c_presc_w-1:0]           r_presc;
    logic [TIME_W-1:0]              r_cnt;
    logic [TIME_W-1:0]              r_delay;
    logic [N_PLAYERS*TIME_W-1:0]    r_rt_time;
    logic [N_PLAYERS-1:0]           r_valid;
    logic [N_PLAYERS-1:0]           r_fs;
    logic [2:0]                     r_winner;
    logic                           r_win_valid;
    logic [TIME_W-1:0]              r_win_time;
    logic [TIME_W-1:0]              r_best;
    logic                           r_best_valid;
    logic                           r_done_entry;

    // Next-state values
    rt_state_e                      w_state_nxt;
    logic [TIME_W-1:0]              w_cnt_nxt;
    logic [TIME_W-1:0]              w_delay_nxt;
    logic [N_PLAYERS*TIME_W-1:0]    w_time_nxt;
    logic [N_PLAYERS-1:0]           w_valid_nxt;
    logic [N_PLAYERS-1:0]           w_fs_nxt;
    logic [2:0]                     w_winner_nxt;
    logic                           w_wv_nxt;
    logic [TIME_W-1:0]              w_wtime_nxt;
    logic [TIME_W-1:0]              w_best_nxt;
    logic                           w_bv_nxt;

    logic                           w_tick;
    logic [DELAY_W-1:0]             w_lfsr;
    logic [TIME_W-1:0]              w_new_delay;
    logic [N_PLAYERS-1:0]           w_cap;
    logic [c_win_w-1:0]             w_first;

    rt_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (DELAY_W)
    ) u_lfsr (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .i_en  (1'b1),
        .o_q   (w_lfsr)
    );

    assign w_tick      = (r_presc == c_presc_max);
    assign w_new_delay = c_min_delay + TIME_W'(w_lfsr);

    // Prescaler restarts on every state change so delays are whole tick periods.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_presc <= '0;
        end else if (clear || (w_state_nxt != r_state) || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_presc_w'(1);
        end
    end

    // Next-state, capture, arbitration and best-time logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_delay_nxt  = r_delay;
        w_time_nxt   = r_rt_time;
        w_valid_nxt  = r_valid;
        w_fs_nxt     = r_fs;
        w_winner_nxt = r_winner;
        w_wv_nxt     = r_win_valid;
        w_wtime_nxt  = r_win_time;
        w_best_nxt   = r_best;
        w_bv_nxt     = r_best_valid;
        w_cap        = '0;
        w_first      = '0;

        case (r_state)
            IDLE: begin
                w_time_nxt   = '0;
                w_valid_nxt  = '0;
                w_fs_nxt     = '0;
                w_winner_nxt = '0;
                w_wv_nxt     = 1'b0;
                w_wtime_nxt  = '0;
                w_cnt_nxt    = '0;
                if (start) begin
                    w_delay_nxt = w_new_delay;
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (w_tick) begin
                    w_cnt_nxt = r_cnt + c_one;
                    if ((r_cnt + c_one) == r_delay) begin
                        w_state_nxt = REACT;
                        w_cnt_nxt   = '0;
                    end
                end
                // Any unlocked press before the light is a false start, including
                // a press on the very cycle the light is about to come on.
                w_cap = btn & ~r_valid;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (w_cap[i]) begin
                        w_fs_nxt[i]                  = 1'b1;
                        w_valid_nxt[i]               = 1'b1;
                        w_time_nxt[i*TIME_W +: TIME_W] = c_timeout;
                    end
                end
                if (&w_valid_nxt) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end
            end

            REACT: begin
                if (w_tick && (r_cnt != c_timeout)) begin
                    w_cnt_nxt = r_cnt + c_one;
                end
                w_cap = btn & ~r_valid;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (w_cap[i]) begin
                        w_valid_nxt[i]               = 1'b1;
                        w_time_nxt[i*TIME_W +: TIME_W] = r_cnt;
                    end
                end
                // Scan downward so the lowest pressing index ends up selected.
                for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                    if (w_cap[i]) begin
                        w_first = c_win_w'(i);
                    end
                end
                if ((|w_cap) && !r_win_valid) begin
                    w_wv_nxt     = 1'b1;
                    w_winner_nxt = 3'(w_first);
                    w_wtime_nxt  = r_cnt;
                end
                if (r_cnt == c_timeout) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (!w_valid_nxt[i]) begin
                            w_valid_nxt[i]               = 1'b1;
                            w_time_nxt[i*TIME_W +: TIME_W] = c_timeout;
                        end
                    end
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else if (&w_valid_nxt) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end
            end

            DONE: begin
                if (r_done_entry && r_win_valid &&
                    (!r_best_valid || (r_win_time < r_best))) begin
                    w_best_nxt = r_win_time;
                    w_bv_nxt   = 1'b1;
                end
                if (start) begin
                    w_time_nxt   = '0;
                    w_valid_nxt  = '0;
                    w_fs_nxt     = '0;
                    w_winner_nxt = '0;
                    w_wv_nxt     = 1'b0;
                    w_wtime_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_delay_nxt  = w_new_delay;
                    w_state_nxt  = WAIT;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything above but keeps the best-time record.
        if (clear) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_delay_nxt  = '0;
            w_time_nxt   = '0;
            w_valid_nxt  = '0;
            w_fs_nxt     = '0;
            w_winner_nxt = '0;
            w_wv_nxt     = 1'b0;
            w_wtime_nxt  = '0;
        end
    end

    // State and result registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_delay      <= '0;
            r_rt_time    <= '0;
            r_valid      <= '0;
            r_fs         <= '0;
            r_winner     <= '0;
            r_win_valid  <= 1'b0;
            r_win_time   <= '0;
            r_best       <= '0;
            r_best_valid <= 1'b0;
            r_done_entry <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_delay      <= w_delay_nxt;
            r_rt_time    <= w_time_nxt;
            r_valid      <= w_valid_nxt;
            r_fs         <= w_fs_nxt;
            r_winner     <= w_winner_nxt;
            r_win_valid  <= w_wv_nxt;
            r_win_time   <= w_wtime_nxt;
            r_best       <= w_best_nxt;
            r_best_valid <= w_bv_nxt;
            r_done_entry <= (w_state_nxt == DONE) && (r_state != DONE);
        end
    end

    assign state        = r_state;
    assign light_on     = (r_state == REACT);
    assign delay_ticks  = r_delay;
    assign rt_time      = r_rt_time;
    assign rt_valid     = r_valid;
    assign false_start  = r_fs;
    assign winner       = r_winner;
    assign winner_valid = r_win_valid;
    assign best_time    = r_best;
    assign best_valid   = r_best_valid;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_timer_multi
// Description : Self-checking bench for reaction_timer_multi. Table of
//               round records plus hand sequences for clear, start/clear
//               collision, false start at light-on and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_multi;

    localparam int TW = 14;
    localparam int NP = 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            clear;
    logic [NP-1:0]   btn;
    logic [1:0]      state;
    logic            light_on;
    logic [TW-1:0]   delay_ticks;
    logic [NP*TW-1:0] rt_time;
    logic [NP-1:0]   rt_valid;
    logic [NP-1:0]   false_start;
    logic [2:0]      winner;
    logic            winner_valid;
    logic [TW-1:0]   best_time;
    logic            best_valid;

    reaction_timer_multi #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .N_PLAYERS (NP),
        .TIME_W    (TW),
        .MIN_DELAY (2),
        .DELAY_W   (3),
        .TIMEOUT   (20),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .start        (start),
        .clear        (clear),
        .btn          (btn),
        .state        (state),
        .light_on     (light_on),
        .delay_ticks  (delay_ticks),
        .rt_time      (rt_time),
        .rt_valid     (rt_valid),
        .false_start  (false_start),
        .winner       (winner),
        .winner_valid (winner_valid),
        .best_time    (best_time),
        .best_valid   (best_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Galois, taps 16,14,13,11, steps every clock.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NP-1:0]    fs;
        logic [NP-1:0]    p1;
        int               e1;
        logic [NP-1:0]    p2;
        int               e2;
        logic [NP*TW-1:0] exp_time;
        logic [NP-1:0]    exp_valid;
        logic [NP-1:0]    exp_fs;
        logic [2:0]       exp_win;
        logic             exp_wv;
        logic [TW-1:0]    exp_best;
        logic             exp_light;
    } round_t;

    round_t rounds[6];

    // One full round from IDLE/DONE: start, optional false starts, timed presses.
    task automatic run_round(input int idx, input round_t r);
        int  d;
        int  c;
        bit  light_seen;
        string pfx;
        pfx = $sformatf("round%0d", idx);
        d = 2 + int'(m_lfsr[2:0]);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({pfx, "_state_wait"}, 64'(state), 64'd1);
        chk({pfx, "_delay"}, 64'(delay_ticks), 64'(d));
        c = 0;
        light_seen = 1'b0;
        if (r.fs != '0) begin
            btn = r.fs;
            step();
            btn = '0;
            c++;
        end
        while (!light_on && state != 2'd3 && c < 300) begin
            step();
            c++;
        end
        if (light_on) begin
            light_seen = 1'b1;
            chk({pfx, "_light_delay_clocks"}, 64'(c), 64'(d * 10));
            if (r.p1 != '0) begin
                repeat (10 * r.e1) step();
                btn = r.p1;
                step();
                btn = '0;
                if (r.p2 != '0) begin
                    repeat (10 * (r.e2 - r.e1) - 1) step();
                    btn = r.p2;
                    step();
                    btn = '0;
                end
            end
            c = 0;
            while (state != 2'd3 && c < 400) begin
                step();
                c++;
            end
        end
        chk({pfx, "_reached_done"}, 64'(state == 2'd3), 64'd1);
        chk({pfx, "_light_seen"}, 64'(light_seen), 64'(r.exp_light));
        chk({pfx, "_light_off"}, 64'(light_on), 64'd0);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s_rt_time%0d", pfx, i), 64'(rt_time[i*TW +: TW]),
                64'(r.exp_time[i*TW +: TW]));
        end
        chk({pfx, "_rt_valid"}, 64'(rt_valid), 64'(r.exp_valid));
        chk({pfx, "_false_start"}, 64'(false_start), 64'(r.exp_fs));
        chk({pfx, "_winner_valid"}, 64'(winner_valid), 64'(r.exp_wv));
        chk({pfx, "_winner"}, 64'(winner), 64'(r.exp_win));
        step();
        chk({pfx, "_best_time"}, 64'(best_time), 64'(r.exp_best));
        chk({pfx, "_best_valid"}, 64'(best_valid), 64'd1);
    endtask

    task automatic chk_round_zeroed(input string pfx);
        chk({pfx, "_state_idle"}, 64'(state), 64'd0);
        chk({pfx, "_light"}, 64'(light_on), 64'd0);
        chk({pfx, "_delay"}, 64'(delay_ticks), 64'd0);
        chk({pfx, "_rt_time"}, 64'(rt_time), 64'd0);
        chk({pfx, "_rt_valid"}, 64'(rt_valid), 64'd0);
        chk({pfx, "_false_start"}, 64'(false_start), 64'd0);
        chk({pfx, "_winner_valid"}, 64'(winner_valid), 64'd0);
        chk({pfx, "_winner"}, 64'(winner), 64'd0);
    endtask

    initial begin
        int d;
        // fs, p1, e1, p2, e2, {t3,t2,t1,t0}, valid, fs, win, wv, best, light
        rounds[0] = '{4'b0000, 4'b0100, 5, 4'b0001, 7, {14'd20, 14'd5, 14'd20, 14'd7},
                      4'b1111, 4'b0000, 3'd2, 1'b1, 14'd5, 1'b1};
        rounds[1] = '{4'b0000, 4'b0010, 8, 4'b0000, 0, {14'd20, 14'd20, 14'd8, 14'd20},
                      4'b1111, 4'b0000, 3'd1, 1'b1, 14'd5, 1'b1};
        rounds[2] = '{4'b0000, 4'b1000, 4, 4'b0000, 0, {14'd4, 14'd20, 14'd20, 14'd20},
                      4'b1111, 4'b0000, 3'd3, 1'b1, 14'd4, 1'b1};
        rounds[3] = '{4'b1111, 4'b0000, 0, 4'b0000, 0, {14'd20, 14'd20, 14'd20, 14'd20},
                      4'b1111, 4'b1111, 3'd0, 1'b0, 14'd4, 1'b0};
        rounds[4] = '{4'b0010, 4'b1101, 3, 4'b0000, 0, {14'd3, 14'd3, 14'd20, 14'd3},
                      4'b1111, 4'b0010, 3'd0, 1'b1, 14'd3, 1'b1};
        rounds[5] = '{4'b0000, 4'b0001, 6, 4'b0110, 9, {14'd20, 14'd9, 14'd9, 14'd6},
                      4'b1111, 4'b0000, 3'd0, 1'b1, 14'd3, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        btn   = '0;
        #23;
        chk_round_zeroed("reset");
        chk("reset_best_time", 64'(best_time), 64'd0);
        chk("reset_best_valid", 64'(best_valid), 64'd0);
        rst_n = 1'b1;
        step();
        step();

        for (int k = 0; k < 6; k++) begin
            run_round(k, rounds[k]);
        end

        // start and clear together from DONE: clear wins, best record kept.
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        chk_round_zeroed("start_clear");
        chk("start_clear_best_time", 64'(best_time), 64'd3);
        chk("start_clear_best_valid", 64'(best_valid), 64'd1);

        // Plain clear from WAIT.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clr_wait_state", 64'(state), 64'd1);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_round_zeroed("clear_wait");
        chk("clear_wait_best_time", 64'(best_time), 64'd3);

        // Press on the exact WAIT->REACT transition cycle is a false start.
        d = 2 + int'(m_lfsr[2:0]);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10 * d - 1) step();
        chk("edge_light_before", 64'(light_on), 64'd0);
        btn = 4'b0001;
        step();
        btn = '0;
        chk("edge_light_after", 64'(light_on), 64'd1);
        chk("edge_false_start", 64'(false_start), 64'h1);
        chk("edge_rt_valid", 64'(rt_valid), 64'h1);
        chk("edge_rt_time0", 64'(rt_time[TW-1:0]), 64'd20);

        // Asynchronous reset in the middle of REACT.
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        chk_round_zeroed("async_reset");
        chk("async_reset_best_time", 64'(best_time), 64'd0);
        chk("async_reset_best_valid", 64'(best_valid), 64'd0);
        #10;
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reaction_timer_multi.md
Name: reaction_timer_multi

Overview:
Parametrised multi-player reaction-timer core, the successor to the single-player board reaction timer. It runs one round at a time: a randomised foreplay delay, then light-on, then per-player reaction capture in ticks. It adds false-start detection, a timeout, winner arbitration and a best-time register. It sits between the button debounce/edge-detect stage and the display/LED driver, and is agnostic to board I/O.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
TICK_HZ, 1000, timing resolution (1 ms default); CLK_HZ/TICK_HZ must be an integer ≥2
N_PLAYERS, 4, number of player buttons (1..8)
TIME_W, 14, width of time values (holds 9999)
MIN_DELAY, 1000, minimum light-on delay in ticks
DELAY_W, 12, random delay span bits; delay = MIN_DELAY + lfsr[DELAY_W-1:0]
TIMEOUT, 9999, reaction timeout in ticks; also the penalty value
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin round
clear  in  1  single-cycle pulse: abort to IDLE
btn  in  N_PLAYERS  single-cycle press pulses, one per player
state  out  2  current FSM state (rt_state_e)
light_on  out  1  high only in REACT
delay_ticks  out  TIME_W  delay chosen for the current round
rt_time  out  N_PLAYERS*TIME_W  per-player result, player i at [i*TIME_W +: TIME_W]
rt_valid  out  N_PLAYERS  player result locked
false_start  out  N_PLAYERS  player pressed during WAIT
winner  out  3  index of the fastest valid player
winner_valid  out  1  winner field meaningful
best_time  out  TIME_W  best winning time since reset
best_valid  out  1  best_time meaningful

Behaviour:
- Reset (async, CPU_RESETN=0):
  - State IDLE.
  - All outputs 0; LFSR loads LFSR_SEED.
- LFSR: 16-bit Galois, taps 16,14,13,11, steps every clock in all states.
- Tick prescaler: counts 0..CLK_HZ/TICK_HZ-1 and emits a 1-cycle tick at the wrap. It is cleared on every state entry, so delays are exact multiples of the period.
- clear has priority over everything. From any state it goes to IDLE next cycle and zeroes rt_*, false_start, winner*, delay_ticks and the tick counter. It leaves best_* untouched.
- IDLE:
  - start → WAIT.
  - Latches delay_ticks = MIN_DELAY + lfsr[DELAY_W-1:0] (zero-extended to TIME_W).
  - Clears the per-round results.
- WAIT:
  - Counts ticks; when count == delay_ticks → REACT with the elapsed counter at 0.
  - btn[i] with rt_valid[i]=0 sets false_start[i]=1, rt_valid[i]=1, rt_time[i]=TIMEOUT.
  - If all players have false-started → DONE with winner_valid=0.
  - start is ignored.
- REACT:
  - light_on=1; elapsed increments per tick and saturates at TIMEOUT.
  - btn[i] with rt_valid[i]=0 sets rt_valid[i]=1 and rt_time[i]=elapsed, registered the cycle after the pulse.
  - The first capturing press sets winner/winner_valid. If several players press in the same cycle, the lowest index wins and all of them capture the same time.
  - Repeat presses by a locked player are ignored.
  - When all rt_valid=1, or elapsed reaches TIMEOUT → DONE. On timeout, unlocked players get rt_time=TIMEOUT and rt_valid=1.
  - start is ignored.
- DONE:
  - light_on=0; results hold.
  - On the entry cycle, if winner_valid and (!best_valid or winner time < best_time), best_time takes the winner time and best_valid=1.
  - start → WAIT with a new delay (same as the IDLE start path); clear → IDLE.
- Simultaneous start and clear: clear wins.
- A btn press in the same cycle as the WAIT→REACT transition counts as a false start.

Decomposition:
- Package reaction_pkg:
  - rt_state_e enum: IDLE=0, WAIT=1, REACT=2, DONE=3.
  - LFSR tap mask constant.
  - Function clog2-based WIN_W helper.
- Sub-module rt_lfsr: 16-bit Galois LFSR with seed parameter, step enable and q output.
- Prescaler, FSM and capture logic stay in reaction_timer_multi.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (10 clocks/tick), N_PLAYERS=4, MIN_DELAY=2, DELAY_W=3, TIMEOUT=20.
1. Reset then start → state=WAIT and delay_ticks∈[2,9]; light_on rises exactly delay_ticks*10 clocks after WAIT entry.
2. In REACT, btn[2] at elapsed=5, then btn[0] at elapsed=7 → rt_time[2]=5, rt_time[0]=7, winner=2. Timeout follows → rt_time[1]=rt_time[3]=20, state=DONE, best_time=5.
3. btn[1] during WAIT → false_start=4'b0010, rt_time[1]=20. In REACT, btn[0], btn[2] and btn[3] press in the same cycle at elapsed=3 → winner=0, all three at 3, DONE.
4. All four btn pulses during WAIT → DONE with winner_valid=0, light_on never asserted, best_* unchanged.
5. Second round won at 8, then third round won at 4 → best_time stays 5, then becomes 4. clear → IDLE, results zeroed, best_time=4 retained.
6. Assert CPU_RESETN=0 mid-REACT → all outputs 0 asynchronously, state=IDLE, best_valid=0. start and clear in the same cycle from DONE → IDLE.
